dla_pe_result_drain: RTL and testbench

Collects per-PE result words from the PE array and merges them onto a single valid/ready output stream toward the output-writer path. Each PE has its own result FIFO so the array can run without backpressure, and an almost-full flag lets the request sequencer throttle issue. It generalises the single-cycle PE result hand-off to any PE count, FIFO depth and result width, and selects round-robin or strict in-order draining with a parameter.

---
 rtl/dla_pe_result_drain_pkg.sv | 22 ++
 rtl/dla_pe_result_drain_fifo.sv | 86 ++++++++
 rtl/dla_pe_result_drain.sv | 129 ++++++++++++
 tb/tb_dla_pe_result_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_pe_result_drain_pkg.sv
// rtl/dla_pe_result_drain_pkg.sv - shared types and helpers for the PE result drain
package dla_pe_result_drain_pkg;

    typedef enum logic {
        RR       = 1'b0,
        IN_ORDER = 1'b1
    } drain_mode_e;

    localparam int DEF_RESULT_W = 64;
    localparam int DEF_ID_W     = 4;

    // Word layout at the default geometry; the top rebuilds it at its own widths.
    typedef struct packed {
        logic [DEF_RESULT_W-1:0] result;
        logic [DEF_ID_W-1:0]     result_id;
    } result_word_t;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dla_pe_result_drain_fifo.sv
// rtl/dla_pe_result_drain_fifo.sv - per-PE result FIFO with registered almost-full and overflow
// Sticky overflow detection is built only when DLA_PE_RESULT_DRAIN_OVERFLOW_CHECK_EN is defined.
module dla_pe_result_drain_fifo #(
    parameter int DATA_W    = 68,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic              clk,
    input  logic              i_aclr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              af_q;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign pop_ok  = i_pop && !o_empty;
    // A full FIFO still takes a word when its head leaves in the same cycle.
    assign push_ok = i_push && (!full || pop_ok);

    always_comb begin
        count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge i_aclr) begin
        if (i_aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            af_q    <= (count_d >= AF_CNT);
        end
    end

    assign o_head        = mem_q[rd_ptr_q];
    assign o_almost_full = af_q;

`ifdef DLA_PE_RESULT_DRAIN_OVERFLOW_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge i_aclr) begin
        if (i_aclr) begin
            ovf_q <= 1'b0;
        end else if (i_push && !push_ok) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: rtl/dla_pe_result_drain.sv
// rtl/dla_pe_result_drain.sv - merges per-PE result FIFOs onto one valid/ready stream
// Overflow flags are live only when DLA_PE_RESULT_DRAIN_OVERFLOW_CHECK_EN is defined.
module dla_pe_result_drain
    import dla_pe_result_drain_pkg::*;
#(
    parameter  int NUM_PES               = 4,
    parameter  int NUM_RESULTS_PER_CYCLE = 1,
    parameter  int NUM_FEATURES          = 2,
    parameter  int RESULT_WIDTH          = 32,
    parameter  int RESULT_ID_WIDTH       = 4,
    parameter  int FIFO_DEPTH            = 8,
    parameter  int ALMOST_FULL_THRESH    = 6,
    parameter  int DRAIN_MODE            = 0,
    localparam int W                     = NUM_RESULTS_PER_CYCLE * NUM_FEATURES * RESULT_WIDTH,
    localparam int IDX_W                 = safe_clog2(NUM_PES)
) (
    input  logic                               clk,
    input  logic                               i_aclr,
    input  logic [NUM_PES-1:0]                 i_pe_valid,
    input  logic [NUM_PES*W-1:0]               i_pe_result,
    input  logic [NUM_PES*RESULT_ID_WIDTH-1:0] i_pe_result_id,
    output logic [NUM_PES-1:0]                 o_almost_full,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [W-1:0]                       o_result,
    output logic [RESULT_ID_WIDTH-1:0]         o_result_id,
    output logic [IDX_W-1:0]                   o_pe_index,
    output logic [NUM_PES-1:0]                 o_overflow
);

    typedef struct packed {
        logic [W-1:0]               result;
        logic [RESULT_ID_WIDTH-1:0] result_id;
    } entry_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PES - 1);

    entry_t               head [NUM_PES];
    logic [NUM_PES-1:0]   empty;
    logic [NUM_PES-1:0]   pop;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;
    logic                 sel_found;
    logic                 load;

    logic                       valid_q;
    logic [W-1:0]               result_q;
    logic [RESULT_ID_WIDTH-1:0] id_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           last_q;
    logic [IDX_W-1:0]           ptr_q;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    for (genvar p = 0; p < NUM_PES; p++) begin : g_pe
        entry_t push_word;

        assign push_word.result    = i_pe_result[p*W +: W];
        assign push_word.result_id = i_pe_result_id[p*RESULT_ID_WIDTH +: RESULT_ID_WIDTH];
        assign pop[p]              = load && (sel_idx == IDX_W'(p));

        dla_pe_result_drain_fifo #(
            .DATA_W    ($bits(entry_t)),
            .DEPTH     (FIFO_DEPTH),
            .AF_THRESH (ALMOST_FULL_THRESH)
        ) u_fifo (
            .clk           (clk),
            .i_aclr        (i_aclr),
            .i_push        (i_pe_valid[p]),
            .i_data        (push_word),
            .i_pop         (pop[p]),
            .o_head        (head[p]),
            .o_empty       (empty[p]),
            .o_almost_full (o_almost_full[p]),
            .o_overflow    (o_overflow[p])
        );
    end

    // Round-robin walks from the PE after the last grant; in-order only ever looks at ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_q;
        if (DRAIN_MODE == int'(IN_ORDER)) begin
            sel_idx   = ptr_q;
            sel_found = !empty[ptr_q];
        end else begin
            for (int k = 0; k < NUM_PES; k++) begin
                cand = wrap_inc(cand);
                if (!sel_found && !empty[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    assign load = (!valid_q || i_ready) && sel_found;

    always_ff @(posedge clk or posedge i_aclr) begin
        if (i_aclr) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            id_q     <= '0;
            idx_q    <= '0;
            last_q   <= LAST_IDX;
            ptr_q    <= '0;
        end else begin
            if (!valid_q || i_ready) begin
                valid_q <= sel_found;
            end
            if (load) begin
                result_q <= head[sel_idx].result;
                id_q     <= head[sel_idx].result_id;
                idx_q    <= sel_idx;
                last_q   <= sel_idx;
                ptr_q    <= wrap_inc(ptr_q);
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_result_id = id_q;
    assign o_pe_index  = idx_q;

endmodule

// File: tb/tb_dla_pe_result_drain.sv
// tb/tb_dla_pe_result_drain.sv - self-checking bench for round-robin and in-order drain instances
module tb_dla_pe_result_drain;

`ifdef DLA_PE_RESULT_DRAIN_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         aclr = 1'b1;
    logic [3:0]   pe_valid = '0;
    logic [255:0] pe_result = '0;
    logic [15:0]  pe_id = '0;
    logic         ready = 1'b1;
    bit           chk_en = 1'b0;

    logic         rr_valid, io_valid;
    logic [63:0]  rr_result, io_result;
    logic [3:0]   rr_id, io_id;
    logic [1:0]   rr_idx, io_idx;
    logic [3:0]   rr_af, io_af, rr_ovf, io_ovf;

    int n_checks = 0;
    int n_fail = 0;

    logic [67:0] mq [2][4][$];
    bit          mv [2];
    logic [63:0] mr [2];
    logic [3:0]  mid [2];
    int          mix [2];
    int          mlast [2];
    int          mptr [2];
    bit          movf [2][4];

    always #5 clk = ~clk;

    dla_pe_result_drain #(.DRAIN_MODE(0)) u_rr (
        .clk(clk), .i_aclr(aclr), .i_pe_valid(pe_valid), .i_pe_result(pe_result),
        .i_pe_result_id(pe_id), .o_almost_full(rr_af), .o_valid(rr_valid), .i_ready(ready),
        .o_result(rr_result), .o_result_id(rr_id), .o_pe_index(rr_idx), .o_overflow(rr_ovf)
    );

    dla_pe_result_drain #(.DRAIN_MODE(1)) u_io (
        .clk(clk), .i_aclr(aclr), .i_pe_valid(pe_valid), .i_pe_result(pe_result),
        .i_pe_result_id(pe_id), .o_almost_full(io_af), .o_valid(io_valid), .i_ready(ready),
        .o_result(io_result), .o_result_id(io_id), .o_pe_index(io_idx), .o_overflow(io_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-PE queues, an output slot, and the arbitration rules stated in plain terms.
    task automatic model_step();
        int sel;
        int c;
        logic [67:0] w;
        for (int m = 0; m < 2; m++) begin
            if (aclr) begin
                for (int p = 0; p < 4; p++) begin
                    mq[m][p].delete();
                    movf[m][p] = 1'b0;
                end
                mv[m] = 1'b0; mr[m] = '0; mid[m] = '0; mix[m] = 0;
                mlast[m] = 3; mptr[m] = 0;
            end else begin
                sel = -1;
                if (m == 1) begin
                    if (mq[m][mptr[m]].size() > 0) sel = mptr[m];
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (mlast[m] + k) % 4;
                        if (sel < 0 && mq[m][c].size() > 0) sel = c;
                    end
                end
                if (!mv[m] || ready) begin
                    mv[m] = (sel >= 0);
                    if (sel >= 0) begin
                        w = mq[m][sel].pop_front();
                        mr[m] = w[63:0];
                        mid[m] = w[67:64];
                        mix[m] = sel;
                        mlast[m] = sel;
                        mptr[m] = (mptr[m] + 1) % 4;
                    end
                end
                for (int p = 0; p < 4; p++) begin
                    if (pe_valid[p]) begin
                        if (mq[m][p].size() < 8) mq[m][p].push_back({pe_id[p*4 +: 4], pe_result[p*64 +: 64]});
                        else if (OVF_EN) movf[m][p] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cmp(input int m, input string pfx, input logic v, input logic [63:0] r,
                       input logic [3:0] id, input logic [1:0] ix, input logic [3:0] af,
                       input logic [3:0] ov);
        logic [3:0] eaf;
        logic [3:0] eov;
        for (int p = 0; p < 4; p++) begin
            eaf[p] = (mq[m][p].size() >= 6);
            eov[p] = movf[m][p];
        end
        check({pfx, "_valid"}, 64'(v), 64'(mv[m]));
        if (mv[m]) begin
            check({pfx, "_result"}, r, mr[m]);
            check({pfx, "_id"}, 64'(id), 64'(mid[m]));
            check({pfx, "_pe_index"}, 64'(ix), 64'(mix[m]));
        end
        check({pfx, "_almost_full"}, 64'(af), 64'(eaf));
        check({pfx, "_overflow"}, 64'(ov), 64'(eov));
    endtask

    initial forever begin
        @(posedge clk or posedge aclr);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp(0, "rr", rr_valid, rr_result, rr_id, rr_idx, rr_af, rr_ovf);
            cmp(1, "io", io_valid, io_result, io_id, io_idx, io_af, io_ovf);
        end
    end

    task automatic set_push(input int p, input logic [63:0] d, input logic [3:0] id);
        pe_valid[p] = 1'b1;
        pe_result[p*64 +: 64] = d;
        pe_id[p*4 +: 4] = id;
    endtask

    task automatic tick();
        @(negedge clk);
        pe_valid = '0;
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        aclr = 1'b0;
        chk_en = 1'b1;
        check("rst_valid", 64'(rr_valid), 64'd0);
        check("rst_result", rr_result, 64'd0);
        check("rst_af", 64'({rr_af, io_af}), 64'd0);
        check("rst_ovf", 64'({rr_ovf, io_ovf}), 64'd0);

        // Single push from PE2: two-cycle latency, then the output empties.
        set_push(2, 64'hA5, 4'd3);
        tick();
        check("sp_not_yet", 64'(rr_valid), 64'd0);
        tick();
        check("sp_valid", 64'(rr_valid), 64'd1);
        check("sp_result", rr_result, 64'hA5);
        check("sp_id", 64'(rr_id), 64'd3);
        check("sp_idx", 64'(rr_idx), 64'd2);
        tick();
        check("sp_drop", 64'(rr_valid), 64'd0);
        do_reset();

        // Two back-to-back bursts from all PEs drain as 0,1,2,3,0,1,2,3.
        for (int p = 0; p < 4; p++) set_push(p, 64'h10 + 64'(p), 4'(p));
        tick();
        for (int p = 0; p < 4; p++) set_push(p, 64'h20 + 64'(p), 4'(p + 4));
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_order_idx", 64'(rr_idx), 64'(k % 4));
            check("rr_order_data", rr_result, ((k < 4) ? 64'h10 : 64'h20) + 64'(k % 4));
        end
        tick();
        check("rr_empty", 64'(rr_valid), 64'd0);
        do_reset();

        // In-order: PE3 waits until PE0, PE1 and PE2 have all been drained.
        set_push(3, 64'h33, 4'd3);
        tick();
        repeat (4) begin
            check("io_wait", 64'(io_valid), 64'd0);
            tick();
        end
        set_push(0, 64'h30, 4'd0);
        tick();
        check("io_lat", 64'(io_valid), 64'd0);
        tick();
        check("io_pe0_valid", 64'(io_valid), 64'd1);
        check("io_pe0_idx", 64'(io_idx), 64'd0);
        check("io_pe0_data", io_result, 64'h30);
        tick();
        check("io_stall", 64'(io_valid), 64'd0);
        set_push(1, 64'h31, 4'd1);
        set_push(2, 64'h32, 4'd2);
        tick();
        tick();
        check("io_pe1", 64'(io_idx), 64'd1);
        tick();
        check("io_pe2", 64'(io_idx), 64'd2);
        tick();
        check("io_pe3_idx", 64'(io_idx), 64'd3);
        check("io_pe3_data", io_result, 64'h33);
        tick();
        check("io_done", 64'(io_valid), 64'd0);
        do_reset();

        // Backpressure on PE1: register holds word 1, FIFO fills with words 2..9, word 10 dropped.
        ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            set_push(1, 64'h100 + 64'(i), 4'(i));
            tick();
            check("bp_af", 64'(rr_af[1]), 64'(i >= 7));
        end
        check("bp_hold", rr_result, 64'h101);
        set_push(1, 64'h10A, 4'd10);
        tick();
        check("bp_ovf", 64'(rr_ovf[1]), 64'(OVF_EN));
        tick();
        check("bp_ovf_sticky", 64'(rr_ovf[1]), 64'(OVF_EN));
        ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            tick();
            check("bp_drain", rr_result, 64'h100 + 64'(k));
        end
        tick();
        check("bp_empty", 64'(rr_valid), 64'd0);
        check("bp_ovf_kept", 64'(rr_ovf[1]), 64'(OVF_EN));
        do_reset();

        // Full FIFO with a pop in the same cycle accepts the push.
        ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            set_push(1, 64'h200 + 64'(i), 4'(i));
            tick();
        end
        check("fp_full_af", 64'(rr_af[1]), 64'd1);
        ready = 1'b1;
        set_push(1, 64'h20A, 4'd10);
        tick();
        check("fp_no_ovf", 64'(rr_ovf[1]), 64'd0);
        check("fp_af_held", 64'(rr_af[1]), 64'd1);
        check("fp_word2", rr_result, 64'h202);
        for (int k = 3; k <= 10; k++) begin
            tick();
            check("fp_drain", rr_result, 64'h200 + 64'(k));
        end
        tick();
        check("fp_empty", 64'(rr_valid), 64'd0);
        do_reset();

        // Reset mid-stream with FIFOs half full and the output word valid.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 4; p++) set_push(p, 64'h300 + 64'(i * 16 + p), 4'(p));
            tick();
        end
        check("ms_valid", 64'(rr_valid), 64'd1);
        #2 aclr = 1'b1;
        #1;
        check("ms_rst_valid", 64'({rr_valid, io_valid}), 64'd0);
        check("ms_rst_result", rr_result | io_result, 64'd0);
        check("ms_rst_id", 64'({rr_id, io_id}), 64'd0);
        check("ms_rst_idx", 64'({rr_idx, io_idx}), 64'd0);
        check("ms_rst_af", 64'({rr_af, io_af}), 64'd0);
        @(negedge clk);
        aclr = 1'b0;
        ready = 1'b1;
        set_push(1, 64'h3FF, 4'd7);
        tick();
        check("ms_lat", 64'(rr_valid), 64'd0);
        tick();
        check("ms_new_valid", 64'(rr_valid), 64'd1);
        check("ms_new_idx", 64'(rr_idx), 64'd1);
        check("ms_new_data", rr_result, 64'h3FF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
